// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the multi-format UART receiver.
//   rx_state_t  - receiver FSM states
//   half_div    - half-bit delay from the detected start edge to the start-bit check
//   entry_width - packed FIFO entry width: {frame_err, parity_err, data}
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   function automatic int unsigned half_div(input int unsigned clk_div);
      return clk_div / 2;
   endfunction

   function automatic int unsigned entry_width(input int unsigned data_bits);
      return data_bits + 2;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO holding received characters.
//   clk, rst  - clock, asynchronous active-high reset
//   push      - write wdata (accepted when not full, or when full with an accepted pop)
//   pop       - drop head entry (ignored when empty)
//   wdata     - entry to write
//   full      - no free entry
//   empty     - no valid entry
//   head      - oldest entry, forced to 0 while empty
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);

   // Extra MSB is the wrap bit: equal pointers mean empty, differing only in it means full.
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_rx_multi.sv
// uart_rx_multi: UART receiver with configurable divisor, character length, parity and
// stop bits, false-start rejection, per-character error flags and a receive FIFO.
//   clk, rst    - clock, asynchronous active-high reset
//   RX          - asynchronous serial input, idle high
//   clr_rdy     - pop head entry
//   clr_ovr     - clear overrun
//   rx_data     - head entry data, LSB first received
//   rdy         - FIFO non-empty
//   parity_err  - head entry parity mismatch
//   frame_err   - head entry saw a low stop sample
//   overrun     - sticky, a completed frame was dropped on a full FIFO
module uart_rx_multi
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 2604,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RX,
   input  logic                 clr_rdy,
   input  logic                 clr_ovr,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rdy,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int unsigned HALF_DIV = half_div(CLK_DIV);
   localparam int unsigned EW       = entry_width(DATA_BITS);
   localparam int unsigned CNT_W    = $clog2(CLK_DIV);
   localparam int unsigned BIT_W    = 4;

   typedef struct packed {
      logic                 frame_err;
      logic                 parity_err;
      logic [DATA_BITS-1:0] data;
   } rx_entry_t;

   rx_state_t            state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [BIT_W-1:0]     bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 parity_err_q, frame_err_q, overrun_q;
   logic                 rx_sync1_q, rx_sync2_q, rx_sync3_q;

   logic                 tick, stop_done, fall, par_exp;
   logic                 fifo_full, fifo_empty, ovr_set;
   rx_entry_t            push_entry;
   logic [EW-1:0]        fifo_head;

   assign tick      = (cnt_q == '0);
   assign fall      = rx_sync3_q && !rx_sync2_q;
   assign par_exp   = (^shift_q) ^ (PARITY_ODD != 0);
   assign stop_done = (state_q == STOP) && tick && (bit_cnt_q == BIT_W'(STOP_BITS - 1));

   // The final stop sample is folded in combinationally so the entry is written at the
   // edge that ends the final stop-sample cycle.
   always_comb begin
      push_entry            = '0;
      push_entry.frame_err  = frame_err_q | ~rx_sync2_q;
      push_entry.parity_err = parity_err_q;
      push_entry.data       = shift_q;
   end

   // Full implies non-empty, so any clr_rdy here is an accepted pop that makes room.
   assign ovr_set = stop_done && fifo_full && !clr_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync1_q   <= 1'b1;
         rx_sync2_q   <= 1'b1;
         rx_sync3_q   <= 1'b1;
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_sync1_q <= RX;
         rx_sync2_q <= rx_sync1_q;
         rx_sync3_q <= rx_sync2_q;
         if (!tick) cnt_q <= cnt_q - 1'b1;
         unique case (state_q)
            IDLE: begin
               if (fall) begin
                  cnt_q   <= CNT_W'(HALF_DIV - 1);
                  state_q <= START;
               end
            end
            START: begin
               if (tick) begin
                  if (!rx_sync2_q) begin
                     cnt_q        <= CNT_W'(CLK_DIV - 1);
                     bit_cnt_q    <= '0;
                     parity_err_q <= 1'b0;
                     frame_err_q  <= 1'b0;
                     state_q      <= DATA;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  shift_q <= {rx_sync2_q, shift_q[DATA_BITS-1:1]};
                  cnt_q   <= CNT_W'(CLK_DIV - 1);
                  if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                     bit_cnt_q <= '0;
                     state_q   <= (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  parity_err_q <= (rx_sync2_q != par_exp);
                  cnt_q        <= CNT_W'(CLK_DIV - 1);
                  bit_cnt_q    <= '0;
                  state_q      <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  if (!rx_sync2_q) frame_err_q <= 1'b1;
                  cnt_q <= CNT_W'(CLK_DIV - 1);
                  if (stop_done) begin
                     state_q <= IDLE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A new drop outranks a clear arriving in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else if (ovr_set) begin
         overrun_q <= 1'b1;
      end else if (clr_ovr) begin
         overrun_q <= 1'b0;
      end
   end

   uart_rx_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (stop_done),
      .pop   (clr_rdy),
      .wdata (push_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign rdy                               = !fifo_empty;
   assign {frame_err, parity_err, rx_data}  = fifo_head;
   assign overrun                           = overrun_q;

endmodule

// File: tb/tb_uart_rx_multi.sv
module tb_uart_rx_multi;

   // Three receivers: 8N1, 8E2, 7O1 with an odd divisor and a 2-entry FIFO.
   localparam int DIV   [3] = '{16, 16, 9};
   localparam int DBITS [3] = '{8, 8, 7};
   localparam int PEN   [3] = '{0, 1, 1};
   localparam int PODD  [3] = '{0, 0, 1};
   localparam int SBITS [3] = '{1, 2, 1};
   localparam int DEPTH [3] = '{4, 4, 2};

   typedef struct {
      logic [8:0] d;
      logic       pe;
      logic       fe;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_line [3];
   logic       clr_rdy [3];
   logic       clr_ovr [3];
   logic [8:0] rxd     [3];
   logic       rdy     [3];
   logic       perr    [3];
   logic       ferr    [3];
   logic       ovr     [3];
   logic [7:0] rxd_a, rxd_b;
   logic [6:0] rxd_c;

   ent_t mq [3][$];
   bit   exp_ovr [3];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   assign rxd[0] = {1'b0, rxd_a};
   assign rxd[1] = {1'b0, rxd_b};
   assign rxd[2] = {2'b0, rxd_c};

   uart_rx_multi #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
      .clk(clk), .rst(rst), .RX(rx_line[0]), .clr_rdy(clr_rdy[0]), .clr_ovr(clr_ovr[0]),
      .rx_data(rxd_a), .rdy(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
      .overrun(ovr[0]));

   uart_rx_multi #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_b (
      .clk(clk), .rst(rst), .RX(rx_line[1]), .clr_rdy(clr_rdy[1]), .clr_ovr(clr_ovr[1]),
      .rx_data(rxd_b), .rdy(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
      .overrun(ovr[1]));

   uart_rx_multi #(.CLK_DIV(9), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1),
                   .STOP_BITS(1), .FIFO_DEPTH(2)) u_dut_c (
      .clk(clk), .rst(rst), .RX(rx_line[2]), .clr_rdy(clr_rdy[2]), .clr_ovr(clr_ovr[2]),
      .rx_data(rxd_c), .rdy(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
      .overrun(ovr[2]));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one character bit by bit, optionally pulsing clr_rdy in the push cycle,
   // then applies the character to the reference queue.
   task automatic send_frame(input int u, input logic [8:0] data, input bit bad_par,
                             input logic [1:0] stops, input bit pop_at_push);
      int         ns       = DBITS[u] + PEN[u] + SBITS[u];
      int         push_off = 2 + DIV[u] / 2 + ns * DIV[u];
      logic [8:0] d        = data & 9'((1 << DBITS[u]) - 1);
      logic       par      = (^d) ^ (PODD[u] != 0) ^ bad_par;
      bit         was_empty = (mq[u].size() == 0) && !pop_at_push;
      logic       bq[$];
      int         cyc  = 0;
      int         rise = -1;
      ent_t       e;
      bit         fe = 1'b0;
      bq.push_back(1'b0);
      for (int i = 0; i < DBITS[u]; i++) bq.push_back(d[i]);
      if (PEN[u] != 0) bq.push_back(par);
      for (int i = 0; i < SBITS[u]; i++) begin
         bq.push_back(stops[i]);
         if (!stops[i]) fe = 1'b1;
      end
      foreach (bq[b]) begin
         for (int j = 0; j < DIV[u]; j++) begin
            rx_line[u] = bq[b];
            clr_rdy[u] = pop_at_push && (cyc == push_off);
            @(posedge clk);
            #1;
            cyc++;
            if (rise < 0 && rdy[u]) rise = cyc;
         end
      end
      clr_rdy[u] = 1'b0;
      if (was_empty) check_eq($sformatf("u%0d_rdy_rise_cycle", u), rise, push_off + 1);
      e.d  = d;
      e.pe = (PEN[u] != 0) && bad_par;
      e.fe = fe;
      if (pop_at_push && mq[u].size() > 0) void'(mq[u].pop_front());
      if (mq[u].size() < DEPTH[u]) mq[u].push_back(e);
      else exp_ovr[u] = 1'b1;
   endtask

   task automatic drain(input int u);
      ent_t e;
      while (mq[u].size() > 0) begin
         e = mq[u].pop_front();
         check_eq($sformatf("u%0d_rdy", u), rdy[u], 1);
         check_eq($sformatf("u%0d_data", u), rxd[u], e.d);
         check_eq($sformatf("u%0d_parity_err", u), perr[u], e.pe);
         check_eq($sformatf("u%0d_frame_err", u), ferr[u], e.fe);
         clr_rdy[u] = 1'b1;
         step(1);
         clr_rdy[u] = 1'b0;
      end
      check_eq($sformatf("u%0d_rdy_empty", u), rdy[u], 0);
      check_eq($sformatf("u%0d_overrun", u), ovr[u], exp_ovr[u]);
      if (exp_ovr[u]) begin
         clr_ovr[u] = 1'b1;
         step(1);
         clr_ovr[u] = 1'b0;
         exp_ovr[u] = 1'b0;
         check_eq($sformatf("u%0d_overrun_clr", u), ovr[u], 0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int u = 0; u < 3; u++) begin
         check_eq($sformatf("%s_u%0d_rdy", tag, u), rdy[u], 0);
         check_eq($sformatf("%s_u%0d_data", tag, u), rxd[u], 0);
         check_eq($sformatf("%s_u%0d_flags", tag, u), {ovr[u], ferr[u], perr[u]}, 0);
      end
   endtask

   initial begin
      for (int u = 0; u < 3; u++) begin
         rx_line[u] = 1'b1;
         clr_rdy[u] = 1'b0;
         clr_ovr[u] = 1'b0;
         exp_ovr[u] = 1'b0;
      end
      step(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      step(5);

      // Basic 8N1 character.
      send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b0);
      drain(0);

      // Even parity: wrong then correct parity bit.
      send_frame(1, 9'h03C, 1'b1, 2'b11, 1'b0);
      send_frame(1, 9'h03C, 1'b0, 2'b11, 1'b0);
      drain(1);

      // Low second stop bit, then the line stays low: one entry only.
      send_frame(1, 9'h05A, 1'b0, 2'b01, 1'b0);
      step(100);
      drain(1);
      rx_line[1] = 1'b1;
      step(20);
      send_frame(1, 9'h0C6, 1'b0, 2'b11, 1'b0);
      drain(1);

      // Break from idle on the 8N1 receiver.
      send_frame(0, 9'h000, 1'b0, 2'b00, 1'b0);
      step(200);
      drain(0);
      rx_line[0] = 1'b1;
      step(20);

      // Five-cycle glitch is rejected, the next character is received.
      rx_line[0] = 1'b0;
      step(5);
      rx_line[0] = 1'b1;
      step(40);
      check_eq("glitch_no_entry", rdy[0], 0);
      send_frame(0, 9'h081, 1'b0, 2'b11, 1'b0);
      drain(0);

      // Overflow without and with a pop in the fifth push cycle.
      for (int i = 1; i <= 5; i++) send_frame(0, 9'(i), 1'b0, 2'b11, 1'b0);
      drain(0);
      for (int i = 1; i <= 5; i++) send_frame(0, 9'(i), 1'b0, 2'b11, i == 5);
      drain(0);

      // Randomized characters on every receiver.
      for (int u = 0; u < 3; u++) begin
         for (int k = 0; k < 3; k++) begin
            repeat (6) begin
               bit         bad_stop = ($urandom_range(0, 5) == 0);
               logic [1:0] stops    = bad_stop ? 2'($urandom_range(0, 2)) : 2'b11;
               send_frame(u, 9'($urandom), $urandom_range(0, 3) == 0, stops, 1'b0);
               if (bad_stop) begin
                  rx_line[u] = 1'b1;
                  step($urandom_range(1, DIV[u]));
               end
            end
            drain(u);
         end
      end

      // Reset in the middle of the data bits aborts the character.
      send_frame(0, 9'h07E, 1'b0, 2'b11, 1'b0);
      rx_line[0] = 1'b0;
      step(16 + 3 * 16);
      rst        = 1'b1;
      rx_line[0] = 1'b1;
      #1;
      check_reset_outputs("midreset");
      for (int u = 0; u < 3; u++) begin
         mq[u].delete();
         exp_ovr[u] = 1'b0;
      end
      step(3);
      rst = 1'b0;
      step(300);
      check_eq("midreset_no_entry", rdy[0], 0);
      send_frame(0, 9'h0C3, 1'b0, 2'b11, 1'b0);
      drain(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_multi.md
# uart_rx_multi

Parametrised UART receiver with configurable baud divisor, character length, optional parity, 1 or 2 stop bits, false-start rejection, per-character error flags and a small receive FIFO. It replaces the fixed 8N1 single-buffer receiver in the command path, so the host can stream bytes faster than the consumer reads them. Frame timing and handshake stay compatible with the existing `rdy`/`clr_rdy` consumers.

## Interface
- `CLK_DIV`, 2604: clk cycles per bit; ≥ 8.
- `DATA_BITS`, 8: character length, 5–9.
- `PARITY_EN`, 0: 1 = parity bit after data.
- `PARITY_ODD`, 0: 1 = odd, 0 = even; ignored if `PARITY_EN` = 0.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries, power of 2, ≥ 2.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `RX` in 1: serial line, asynchronous to `clk`, idle high.
- `clr_rdy` in 1: pop head entry; ignored when empty.
- `clr_ovr` in 1: clear `overrun`.
- `rx_data` out `DATA_BITS`: head entry data, LSB = first received bit.
- `rdy` out 1: FIFO non-empty.
- `parity_err` out 1: head entry parity mismatch.
- `frame_err` out 1: head entry had a low stop sample.
- `overrun` out 1: sticky; a completed frame was dropped because the FIFO was full.

## Operation
- `RX` double-flopped, with a third flop for edge detection. Sync flops reset to 1. All sampling uses the second flop.
- FSM states:
  - IDLE: on falling edge (third flop 1, second flop 0), load half-bit count and go to START.
  - START: at half-bit expiry, sample. If 0, go to DATA. If 1, the start was a glitch; return to IDLE with no push.
  - DATA: one sample per bit period, shifted in LSB first. After `DATA_BITS` samples go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: sample and compare against the XOR of the data bits (inverted if `PARITY_ODD`). A mismatch sets the per-frame `parity_err`.
  - STOP: `STOP_BITS` samples. Any 0 sample sets `frame_err`. After the final stop sample, push `{frame_err, parity_err, data}` and go to IDLE in the same cycle.
- A frame with errors is still pushed.
- A line held low (break) produces one frame_err entry. No new frame starts until the line has returned high and then fallen again.
- FIFO behaviour:
  - Push when full and no pop in that cycle: drop the frame and set `overrun`.
  - Push and pop in the same cycle, full: both succeed, `overrun` unchanged.
  - Push and pop in the same cycle, empty: the push succeeds, the pop is ignored.
- `overrun` behaviour:
  - Cleared by `clr_ovr`.
  - If a set and `clr_ovr` occur in the same cycle, the set wins.
- Reset mid-frame aborts the frame. Nothing is pushed.

## Timing
- Reset values:
  - FSM in IDLE, FIFO empty.
  - `rdy`, `parity_err`, `frame_err`, `overrun` all 0.
  - `rx_data` = 0.
- The falling `RX` edge is detected 2 cycles after it reaches the `RX` pin (synchroniser delay).
- Let T0 be the detection cycle. Sample times:
  - Start check at T0 + `CLK_DIV`/2 (integer divide).
  - Sample k (k = 1..`DATA_BITS`+`PARITY_EN`+`STOP_BITS`) at T0 + `CLK_DIV`/2 + k·`CLK_DIV`.
- FIFO write occurs at the clock edge ending the final stop-sample cycle. `rdy` and the head outputs are valid from the next cycle.
- `clr_rdy` asserted in cycle N: head advances at the end of N. Outputs show the next entry, or `rdy` = 0, from N+1.
- Head outputs (`rx_data`, `parity_err`, `frame_err`) are registered FIFO storage, with no combinational path from `RX`.
- The earliest next frame can be detected in the cycle after the final stop sample. Back-to-back frames at nominal baud are received without loss.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - Entry struct `rx_entry_t` parametrised by width via `DATA_BITS`+2 packing.
  - Helper constant `HALF_DIV` = `CLK_DIV`/2.
- Sub-module `uart_rx_fifo`: synchronous FIFO, params WIDTH and DEPTH, ports push/pop/full/empty/head. Pointer width is $clog2(DEPTH)+1, using the wrap bit for full/empty.
- Baud counter, bit counter, shifter and FSM stay in `uart_rx_multi`.

## Test plan
- Default params (`CLK_DIV` 16 in sim), send 0xA5 8N1: `rdy` rises 1 cycle after the final stop sample, `rx_data` = 0xA5, both error flags 0. `clr_rdy` drops `rdy` next cycle.
- `PARITY_EN` 1, even parity:
  - Send 0x3C with parity bit 1: `parity_err` = 1, `rx_data` = 0x3C.
  - Resend with parity 0: `parity_err` = 0.
- `STOP_BITS` 2, send 0x5A with the second stop bit 0: entry pushed with `frame_err` = 1. Hold `RX` low afterwards: no further entries until `RX` goes high then low.
- Glitch low for 5 cycles (`CLK_DIV` 16): no entry, FSM back in IDLE. The next valid 0x81 is received correctly.
- `FIFO_DEPTH` 4, five back-to-back frames 0x01..0x05 without `clr_rdy`:
  - Pops return 0x01..0x04 in order. `overrun` = 1; `clr_ovr` clears it.
  - Repeat with a pop in the 5th push cycle: no overrun, 0x05 retained.
- Assert `rst` midway through DATA bits: all outputs reset immediately, no entry appears. The following frame 0xC3 is received cleanly.
